// File: rtl/dot_accumulator_pkg.sv
// Shared definitions for the dot-product accumulator.
// Holds the width helpers that size the accumulator and the term counter,
// and the two-state encoding used by the accumulate/hold controller.
package dot_accumulator_pkg;

  // Default operand width and maximum terms per group.
  localparam int DEFAULT_W = 4;
  localparam int DEFAULT_N = 4;

  // Accumulator width: a 2*w-bit product summed n times needs $clog2(n)
  // extra bits, so n*(2^(2w)-1) can never overflow.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Term counter width: must be able to represent the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Controller states.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/dot_accumulator.sv
// dot_accumulator: MAC back-end that sums a stream of unsigned products into
// groups of up to N terms and presents each group sum with its term count.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_valid   - in_prod is valid
//   in_ready   - block accepts a product this cycle (high in ACCUM)
//   in_prod    - unsigned 2*W-bit product
//   in_last    - accepted product closes the group early
//   out_valid  - out_sum/out_count are valid (high in HOLD)
//   out_ready  - consumer takes the result
//   out_sum    - unsigned group sum, ACC_W bits
//   out_count  - number of terms in the group, 1..N
module dot_accumulator
  import dot_accumulator_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N,
  localparam int ACC_W = acc_width(W, N),
  localparam int CW = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CW-1:0]    out_count_q, out_count_d;

  logic [ACC_W-1:0] sum_next;
  logic [CW-1:0]    cnt_next;

  // Next-state and datapath. The closing product is folded straight into
  // the result register so the accumulator is already clear for the next
  // group when HOLD is entered. No accept happens in HOLD, so products
  // offered there simply wait for in_ready to return.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    sum_next    = acc_q + ACC_W'(in_prod);
    cnt_next    = cnt_q + CW'(1);

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if ((cnt_next == CW'(N)) || in_last) begin
            out_sum_d   = sum_next;
            out_count_d = cnt_next;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = HOLD;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_next;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
    endcase
  end

  // State and result registers; reset discards any partial or held group.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Testbench for dot_accumulator with W=4, N=4.
// A cycle-level reference model pushes each closed group onto a scoreboard
// queue; results are popped and compared when the design raises out_valid.
module tb_dot_accumulator;

  localparam int W     = 4;
  localparam int N     = 4;
  localparam int ACC_W = 10;
  localparam int CW    = 3;

  typedef struct {
    int sum;
    int count;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_count;

  int checks   = 0;
  int failures = 0;

  result_t exp_q[$];
  result_t cur_exp;
  int      last_sum   = -1;
  int      last_count = -1;
  logic    prev_valid = 1'b0;

  // Reference model state
  bit m_hold = 1'b0;
  int m_acc  = 0;
  int m_cnt  = 0;

  dot_accumulator #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the clock edge, then
  // check handshake state and any presented result just after the edge.
  task automatic step(input logic v, input int p, input logic l, input logic r, input logic rs);
    int nacc;
    int ncnt;
    rst       = rs;
    in_valid  = v;
    in_prod   = 8'(p);
    in_last   = l;
    out_ready = r;
    @(posedge clk);
    if (rs) begin
      m_hold = 1'b0;
      m_acc  = 0;
      m_cnt  = 0;
      exp_q.delete();
    end else if (!m_hold) begin
      if (v) begin
        nacc = m_acc + p;
        ncnt = m_cnt + 1;
        if (ncnt == N || l) begin
          exp_q.push_back('{sum: nacc, count: ncnt});
          m_acc  = 0;
          m_cnt  = 0;
          m_hold = 1'b1;
        end else begin
          m_acc = nacc;
          m_cnt = ncnt;
        end
      end
    end else if (r) begin
      m_hold = 1'b0;
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_hold));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        failures++;
        $error("[TB] FAIL unexpected_output observed=%0d expected=none", out_sum);
      end
      if (exp_q.size() > 0) begin
        cur_exp    = exp_q.pop_front();
        last_sum   = cur_exp.sum;
        last_count = cur_exp.count;
      end
    end
    if (out_valid === 1'b1) begin
      chk("out_sum", 32'(out_sum), 32'(cur_exp.sum));
      chk("out_count", 32'(out_count), 32'(cur_exp.count));
    end
    prev_valid = out_valid;
  endtask

  initial begin
    cur_exp = '{sum: 0, count: 0};
    $display("[TB] starting dot_accumulator bench");

    // Reset held two cycles while a product is offered
    step(1'b1, 200, 1'b0, 1'b1, 1'b1);
    step(1'b1, 200, 1'b0, 1'b1, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);

    // Full group of maximum products
    for (int i = 0; i < 4; i++) step(1'b1, 225, 1'b0, 1'b1, 1'b0);
    chk("full_valid_after_4th", 32'(out_valid), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("full_sum", 32'(last_sum), 32'd900);
    chk("full_count", 32'(last_count), 32'd4);

    // Early termination with in_last, then a fresh single-term group
    step(1'b1, 6, 1'b0, 1'b1, 1'b0);
    step(1'b1, 10, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("early_sum", 32'(last_sum), 32'd16);
    chk("early_count", 32'(last_count), 32'd2);
    step(1'b1, 3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("restart_sum", 32'(last_sum), 32'd3);
    chk("restart_count", 32'(last_count), 32'd1);

    // Backpressure: result held five cycles while a product waits
    for (int i = 0; i < 4; i++) step(1'b1, 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 9, 1'b1, 1'b0, 1'b0);
    chk("bp_sum", 32'(last_sum), 32'd20);
    chk("bp_count", 32'(last_count), 32'd4);
    step(1'b1, 9, 1'b1, 1'b1, 1'b0);
    step(1'b1, 9, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("bp_waiting_sum", 32'(last_sum), 32'd9);
    chk("bp_waiting_count", 32'(last_count), 32'd1);

    // Gapped input; in_last toggles during idle cycles and must be ignored
    for (int v = 1; v <= 4; v++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) step(1'b0, $urandom_range(0, 255), 1'b1, 1'b1, 1'b0);
      step(1'b1, v, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("gap_sum", 32'(last_sum), 32'd10);
    chk("gap_count", 32'(last_count), 32'd4);

    // Reset mid-group discards the partial 110
    step(1'b1, 50, 1'b0, 1'b1, 1'b0);
    step(1'b1, 60, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_sum", 32'(last_sum), 32'd4);
    chk("rst_mid_count", 32'(last_count), 32'd4);

    // Idle tail: every expected result must have been presented
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

- Downstream consumer of the sequential multiplier.
- Accepts a stream of `2*W`-bit products over a valid/ready handshake.
- Sums them into a dot-product result of `N` terms, or fewer if `in_last` terminates the group early.
- Presents the sum with a term count on a held output handshake.
- Sits between the multiplier output and the result/display logic; it is the MAC back-end of the datapath.

## Interface

**Parameters**
- `W`, default 4: multiplier operand width; products are `2*W` bits.
- `N`, default 4: maximum terms per group, ≥1.

**Ports**
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_prod` is valid.
- `in_ready`, output, 1: block can accept a product this cycle.
- `in_prod`, input, `2*W`: unsigned product.
- `in_last`, input, 1: the accepted product closes the group early.
- `out_valid`, output, 1: `out_sum` and `out_count` are valid.
- `out_ready`, input, 1: the consumer takes the result.
- `out_sum`, output, `ACC_W` = `2*W + $clog2(N)`: unsigned group sum.
- `out_count`, output, `CW` = `$clog2(N+1)`: number of terms in the group, 1..N.

## Operation

**State machine**
- `ACCUM` (reset state): `in_ready=1`, `out_valid=0`.
- `HOLD`: `in_ready=0`, `out_valid=1`.

**Accept**
- A product is accepted when `in_valid && in_ready`.
- Accumulate: `acc <= acc + zero-extend(in_prod)`, `cnt <= cnt + 1`.

**Group close**
- A group closes on the accepting cycle when `cnt+1 == N` or `in_last=1`.
- On close: `out_sum <= acc + in_prod`, `out_count <= cnt + 1`, `acc <= 0`, `cnt <= 0`, next state is `HOLD`.

**Release**
- In `HOLD`, when `out_ready=1` the result is consumed and the next state is `ACCUM`.
- `out_sum` and `out_count` stay stable in `HOLD` until consumed.

**Don't-care and ignored inputs**
- `in_last` with `in_valid=0` is ignored.
- `in_prod` is don't-care when not accepted.

**Width and overflow**
- `ACC_W` is sized so that `N*(2^(2W)-1)` never overflows, so no saturation logic is needed.
- All arithmetic is unsigned.

**Reset values**
- Outputs: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`.
- Internal: `acc=0`, `cnt=0`, state `ACCUM`.

**Reset mid-operation**
- Any partial group and any held result are discarded.
- No output is produced for them.

## Timing

- Throughput: one product per cycle while in `ACCUM`.
- Latency: `out_valid` rises the cycle after the closing product is accepted.
- Minimum group period is `terms + 1` cycles, because `HOLD` lasts at least one cycle.
- `in_ready` and `out_valid` are registered state decodes; neither depends combinationally on `in_valid` or `out_ready`.
- In `HOLD` with `out_ready=1`: `in_ready` returns to 1 on the next cycle. There is no same-cycle accept-while-release; products presented during `HOLD` wait.
- `out_valid` must not drop until it has been consumed.
- `N=1`: every accepted product closes a group; `out_count=1` always.
- `in_last` on the N-th term: a single close, identical to a normal close.

## Structure

- The shared package holds:
  - the width helpers `ACC_W(W,N)` and `CW(N)`;
  - the state encoding `ACCUM`/`HOLD`.
- Single module, no sub-modules; the datapath is one adder plus counter.
- An optional top-level wrapper `seq_mac_top` may pair it with the multiplier; that wrapper is out of scope here.

## Test plan

All scenarios use `W=4`, `N=4`.

1. **Reset:** assert `rst` for 2 cycles with `in_valid=1` → `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, and nothing is accumulated.
2. **Full group at max value:** stream 225 ×4 back-to-back with `out_ready=1` → `out_sum=900`, `out_count=4`, `out_valid` high one cycle after the 4th accept.
3. **Early last:** stream 6, then 10 with `in_last=1` → `out_sum=16`, `out_count=2`; the next group starts from 0.
4. **Backpressure:** close a group (sum 20) with `out_ready=0` for 5 cycles while `in_valid=1` → `in_ready=0`, result stable for all 5 cycles, and no product is lost once released.
5. **Gapped input:** stream 1, 2, 3, 4 with random `in_valid` gaps → `out_sum=10`, `out_count=4`.
6. **Reset mid-group:** accept 50 and 60, assert `rst`, then stream 1 ×4 → `out_sum=4`; the partial sum 110 never appears.
